// File: rtl/fp_mant_align.sv
// Aligns four packed FP operands to a common exponent for the adder tree.
// Two-stage valid/ready pipeline: S1 holds raw operands, S2 holds aligned signed mantissas.
module fp_mant_align #(
   parameter int expWidth = 4,
   parameter int manWidth = 3
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [3:0]                  in_sign,
   input  logic [expWidth*4-1:0]       in_exp,
   input  logic [manWidth*4-1:0]       in_man,
   input  logic [expWidth-1:0]         in_max_exp,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [4*(manWidth+5)-1:0]   out_man,
   output logic [expWidth-1:0]         out_exp,
   output logic                        out_err
);

   localparam int W  = manWidth + 4;
   localparam int LW = W + 1;

   logic                      r_s1_valid;
   logic [3:0]                r_s1_sign;
   logic [expWidth*4-1:0]     r_s1_exp;
   logic [manWidth*4-1:0]     r_s1_man;
   logic [expWidth-1:0]       r_s1_max;

   logic                      r_s2_valid;
   logic [4*LW-1:0]           r_s2_man;
   logic [expWidth-1:0]       r_s2_exp;
   logic                      r_s2_err;

   logic                      w_s1_en;
   logic                      w_s2_en;
   logic [expWidth-1:0]       w_e_common;
   logic [4*LW-1:0]           w_lane;
   logic [3:0]                w_lane_bad;

   // Right shift with every shifted-out bit folded into bit 0; beyond the width only presence survives.
   function automatic logic [W-1:0] shift_sticky(input logic [W-1:0] mag,
                                                  input logic [expWidth-1:0] d);
      logic [W-1:0] lost_mask;
      logic [W-1:0] res;
      if (int'(d) >= W) begin
         res = (mag != '0) ? W'(1) : '0;
      end else begin
         lost_mask = ~({W{1'b1}} << d);
         res       = (mag >> d) | {{(W-1){1'b0}}, |(mag & lost_mask)};
      end
      return res;
   endfunction

   assign w_s2_en    = !r_s2_valid || out_ready;
   assign w_s1_en    = !r_s1_valid || w_s2_en;
   assign in_ready   = w_s1_en;
   assign w_e_common = (r_s1_max == '0) ? expWidth'(1) : r_s1_max;

   for (genvar i = 0; i < 4; i++) begin : g_lane
      logic [expWidth-1:0] w_e;
      logic [expWidth-1:0] w_eff;
      logic [expWidth-1:0] w_d;
      logic                w_h;
      logic                w_bad;
      logic [W-1:0]        w_mag;
      logic [W-1:0]        w_shr;

      assign w_e   = r_s1_exp[expWidth*i +: expWidth];
      assign w_h   = (w_e != '0);
      assign w_eff = w_h ? w_e : expWidth'(1);
      assign w_bad = (w_eff > w_e_common);
      assign w_d   = w_e_common - w_eff;
      assign w_mag = {w_h, r_s1_man[manWidth*i +: manWidth], 3'b000};
      assign w_shr = shift_sticky(w_mag, w_d);

      assign w_lane_bad[i]       = w_bad;
      assign w_lane[LW*i +: LW]  = w_bad        ? '0 :
                                   r_s1_sign[i] ? -{1'b0, w_shr} : {1'b0, w_shr};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_sign  <= '0;
         r_s1_exp   <= '0;
         r_s1_man   <= '0;
         r_s1_max   <= '0;
      end else if (w_s1_en) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1_sign <= in_sign;
            r_s1_exp  <= in_exp;
            r_s1_man  <= in_man;
            r_s1_max  <= in_max_exp;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_valid <= 1'b0;
         r_s2_man   <= '0;
         r_s2_exp   <= '0;
         r_s2_err   <= 1'b0;
      end else if (w_s2_en) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_man <= w_lane;
            r_s2_exp <= w_e_common;
            r_s2_err <= |w_lane_bad;
         end
      end
   end

   assign out_valid = r_s2_valid;
   assign out_man   = r_s2_man;
   assign out_exp   = r_s2_exp;
   assign out_err   = r_s2_err;

endmodule

// File: tb/tb_fp_mant_align.sv
// Bench for fp_mant_align: arithmetic reference model, per-cycle output compare, directed and random traffic.
module tb_fp_mant_align;

   typedef struct packed {
      logic [31:0] man;
      logic [3:0]  exp;
      logic        err;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_sign;
   logic [15:0] in_exp;
   logic [11:0] in_man;
   logic [3:0]  in_max_exp;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_man;
   logic [3:0]  out_exp;
   logic        out_err;

   int    checks   = 0;
   int    failures = 0;
   beat_t exp_q[$];
   bit    bp_rand  = 0;
   bit    bp_phase = 0;
   bit    saw_drop = 0;
   bit    hold_pending = 0;
   logic [31:0] h_man;
   logic [3:0]  h_exp;
   logic        h_err;

   fp_mant_align #(.expWidth(4), .manWidth(3)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_sign(in_sign), .in_exp(in_exp), .in_man(in_man), .in_max_exp(in_max_exp),
      .out_valid(out_valid), .out_ready(out_ready), .out_man(out_man),
      .out_exp(out_exp), .out_err(out_err)
   );

   always #5 clk = ~clk;

   // Reference: plain integer arithmetic on the alignment rules.
   function automatic beat_t model(input logic [3:0] s, input logic [15:0] e,
                                   input logic [11:0] m, input logic [3:0] mx);
      beat_t b;
      int    big_e;
      b.man = '0;
      b.err = 1'b0;
      big_e = (mx == 0) ? 1 : int'(mx);
      b.exp = big_e[3:0];
      for (int i = 0; i < 4; i++) begin
         int ev, mv, ef, mag, d, r, v;
         ev  = int'(e[4*i +: 4]);
         mv  = int'(m[3*i +: 3]);
         ef  = (ev == 0) ? 1 : ev;
         mag = ((ev != 0) ? 64 : 0) + mv * 8;
         if (ef > big_e) begin
            r     = 0;
            b.err = 1'b1;
         end else begin
            d = big_e - ef;
            if (d >= 7) r = (mag != 0) ? 1 : 0;
            else        r = (mag / (1 << d)) | (((mag % (1 << d)) != 0) ? 1 : 0);
         end
         v = s[i] ? (256 - r) % 256 : r;
         b.man[8*i +: 8] = v[7:0];
      end
      return b;
   endfunction

   task automatic pin(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         hold_pending = 0;
      end else begin
         if (bp_phase && !in_ready) saw_drop = 1;
         if (in_valid && in_ready) exp_q.push_back(model(in_sign, in_exp, in_man, in_max_exp));
         if (hold_pending) begin
            checks++;
            if (!out_valid || out_man !== h_man || out_exp !== h_exp || out_err !== h_err) begin
               failures++;
               $display("FAIL stall_hold got v=%b man=%h exp=%h err=%b want v=1 man=%h exp=%h err=%b",
                        out_valid, out_man, out_exp, out_err, h_man, h_exp, h_err);
            end
         end
         hold_pending = out_valid && !out_ready;
         h_man = out_man;
         h_exp = out_exp;
         h_err = out_err;
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_beat got man=%h exp=%h err=%b want none", out_man, out_exp, out_err);
            end else begin
               beat_t w;
               w = exp_q.pop_front();
               if (out_man !== w.man || out_exp !== w.exp || out_err !== w.err) begin
                  failures++;
                  $display("FAIL beat got man=%h exp=%h err=%b want man=%h exp=%h err=%b",
                           out_man, out_exp, out_err, w.man, w.exp, w.err);
               end
            end
         end
      end
   end

   task automatic send(input logic [3:0] s, input logic [15:0] e, input logic [11:0] m, input logic [3:0] mx);
      int   g;
      logic acc;
      in_valid = 1'b1;
      in_sign = s; in_exp = e; in_man = m; in_max_exp = mx;
      g = 0;
      do begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         if (bp_rand) out_ready = ($urandom_range(0, 3) != 0);
         g++;
      end while (!acc && g < 200);
      if (!acc) begin
         checks++;
         failures++;
         $display("FAIL send_timeout got in_ready=0 want 1 within 200 cycles");
      end
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         if (bp_rand) out_ready = ($urandom_range(0, 3) != 0);
      end
   endtask

   task automatic drain();
      int g;
      g = 0;
      while ((exp_q.size() != 0 || out_valid) && g < 100) begin
         @(posedge clk);
         #1;
         g++;
      end
      pin("drain_queue_empty", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic send_pinned(input string name, input logic [3:0] s, input logic [15:0] e,
                              input logic [11:0] m, input logic [3:0] mx,
                              input logic [31:0] want_man, input logic [31:0] mask,
                              input logic [3:0] want_exp, input logic want_err);
      beat_t b;
      b = model(s, e, m, mx);
      pin({name, "_man"}, b.man & mask, want_man);
      pin({name, "_exp"}, 32'(b.exp), 32'(want_exp));
      pin({name, "_err"}, 32'(b.err), 32'(want_err));
      send(s, e, m, mx);
   endtask

   initial begin
      int n_after;
      rst_n = 1'b0;
      in_valid = 1'b0; in_sign = '0; in_exp = '0; in_man = '0; in_max_exp = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      pin("rst_out_valid", 32'(out_valid), 32'd0);
      pin("rst_out_man", out_man, 32'd0);
      pin("rst_out_exp", 32'(out_exp), 32'd0);
      pin("rst_out_err", 32'(out_err), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      pin("rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;

      send_pinned("basic", 4'b0010, {4'd0, 4'd3, 4'd5, 4'd5}, {3'b100, 3'b100, 3'b100, 3'b100}, 4'd5,
                  32'h0218A060, 32'hFFFFFFFF, 4'd5, 1'b0);
      send_pinned("sticky_m6", 4'b0000, 16'h0001, 12'h007, 4'd6, 32'h03, 32'hFF, 4'd6, 1'b0);
      send_pinned("far_m8", 4'b0000, 16'h0001, 12'h007, 4'd8, 32'h01, 32'hFF, 4'd8, 1'b0);
      send_pinned("far_m15", 4'b0000, 16'h0001, 12'h007, 4'd15, 32'h01, 32'hFF, 4'd15, 1'b0);
      send_pinned("zero_mag", 4'b0000, 16'h0000, 12'h000, 4'd15, 32'h00, 32'hFF, 4'd15, 1'b0);
      send_pinned("neg_zero", 4'b0001, 16'h0000, 12'h000, 4'd15, 32'h00, 32'hFF, 4'd15, 1'b0);
      send_pinned("all_zero_exp", 4'b0000, 16'h0000, {3'b001, 3'b001, 3'b001, 3'b001}, 4'd0,
                  32'h08080808, 32'hFFFFFFFF, 4'd1, 1'b0);
      send_pinned("err_beat", 4'b0000, {4'd5, 4'd7, 4'd5, 4'd5}, 12'hFFF, 4'd5,
                  32'h00000000, 32'h00FF0000, 4'd5, 1'b1);
      send_pinned("after_err", 4'b0000, {4'd5, 4'd5, 4'd5, 4'd5}, 12'hFFF, 4'd5,
                  32'h78787878, 32'hFFFFFFFF, 4'd5, 1'b0);
      drain();

      // Six back-to-back beats with a four-cycle downstream stall.
      bp_phase = 1;
      saw_drop = 0;
      fork
         begin
            for (int k = 0; k < 6; k++) send(4'b0000, 16'h0000, 12'(k), 4'd1);
         end
         begin
            repeat (2) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (4) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();
      bp_phase = 0;
      pin("bp_in_ready_dropped", 32'(saw_drop), 32'd1);

      bp_rand = 1;
      for (int n = 0; n < 300; n++) begin
         logic [15:0] e;
         logic [3:0]  mx;
         e  = 16'($urandom);
         mx = 4'd0;
         for (int i = 0; i < 4; i++) if (e[4*i +: 4] > mx) mx = e[4*i +: 4];
         if ($urandom_range(0, 3) == 0) mx = 4'($urandom);
         send(4'($urandom), e, 12'($urandom), mx);
         if ($urandom_range(0, 3) == 0) idle(1);
      end
      bp_rand = 0;
      out_ready = 1'b1;
      drain();

      // Asynchronous reset with two beats in flight.
      send(4'b0001, 16'h5555, 12'h924, 4'd5);
      send(4'b0010, 16'h3333, 12'h249, 4'd3);
      #2 rst_n = 1'b0;
      #1;
      pin("async_rst_out_valid", 32'(out_valid), 32'd0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      pin("post_rst_in_ready", 32'(in_ready), 32'd1);
      n_after = 0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid) n_after++;
      end
      pin("post_rst_no_stale", 32'(n_after), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
